// File: rtl/trap_sequencer.sv
// trap_sequencer: takes an interrupt at a non-stalled instruction boundary, saves the
// resume PC to mepc, flushes and redirects fetch to the vector, and on MRET flushes
// and redirects fetch back to mepc. Single level, no nesting.
//   clk, rst (active-low async)         clock and reset
//   inter_req/inter_addr/inter_sel      request, vector address and cause from the detector
//   mret, stall, pc_cur                 execute-stage MRET, pipeline stall, oldest un-retired PC
//   epc_rdata                           current mepc from the CSR file
//   epc_we/epc_wdata                    mepc write port (combinational while waiting for a boundary)
//   flush, pc_redirect, pc_target       pipeline kill and fetch redirect
//   inter_ack, in_handler, cause, busy  status back to the detector and core
module trap_sequencer #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] CODE_SEGMENT = '0,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inter_req,
   input  logic [XLEN-1:0] inter_addr,
   input  logic [2:0]      inter_sel,
   input  logic            mret,
   input  logic            stall,
   input  logic [XLEN-1:0] pc_cur,
   input  logic [XLEN-1:0] epc_rdata,
   output logic            epc_we,
   output logic [XLEN-1:0] epc_wdata,
   output logic            flush,
   output logic            pc_redirect,
   output logic [XLEN-1:0] pc_target,
   output logic            inter_ack,
   output logic            in_handler,
   output logic [2:0]      cause,
   output logic            busy
);
   localparam logic [2:0] IDLE         = 3'd0;
   localparam logic [2:0] WAIT_BND     = 3'd1;
   localparam logic [2:0] FLUSH        = 3'd2;
   localparam logic [2:0] REDIRECT     = 3'd3;
   localparam logic [2:0] HANDLER      = 3'd4;
   localparam logic [2:0] RET_FLUSH    = 3'd5;
   localparam logic [2:0] RET_REDIRECT = 3'd6;
   localparam logic [3:0] DRAIN_INIT   = 4'(DRAIN_CYCLES - 1);

   logic [2:0]      state;
   logic [3:0]      cnt;
   logic [XLEN-1:0] vec;
   logic [XLEN:0]   diff;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         vec   <= '0;
         cause <= '0;
      end else
         case (state)
            IDLE:
               if (inter_req) begin
                  vec   <= inter_addr;
                  cause <= inter_sel;
                  state <= WAIT_BND;
               end
            WAIT_BND:
               if (!stall) begin
                  cnt   <= DRAIN_INIT;
                  state <= FLUSH;
               end
            FLUSH, RET_FLUSH:
               if (cnt == '0) state <= (state == FLUSH) ? REDIRECT : RET_REDIRECT;
               else cnt <= cnt - 4'd1;
            REDIRECT: state <= HANDLER;
            // inter_req is deliberately not looked at here: no nesting, mret wins
            HANDLER:
               if (mret && !stall) begin
                  cnt   <= DRAIN_INIT;
                  state <= RET_FLUSH;
               end
            default: state <= IDLE;
         endcase

   // borrow bit of pc_cur - CODE_SEGMENT flags a PC below the legal code segment
   assign diff        = {1'b0, pc_cur} - {1'b0, CODE_SEGMENT};
   assign epc_we      = (state == WAIT_BND) && !stall;
   assign epc_wdata   = (state != WAIT_BND) ? '0 : diff[XLEN] ? CODE_SEGMENT : pc_cur;
   assign flush       = (state == FLUSH) || (state == RET_FLUSH);
   assign pc_redirect = (state == REDIRECT) || (state == RET_REDIRECT);
   assign inter_ack   = (state == REDIRECT);
   // epc_rdata is taken live so a mepc written by the handler is honoured
   assign pc_target   = (state == REDIRECT) ? vec : (state == RET_REDIRECT) ? epc_rdata : '0;
   assign in_handler  = (state == HANDLER) || (state == RET_FLUSH) || (state == RET_REDIRECT);
   assign busy        = (state != IDLE);
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed bench for trap_sequencer; a second instance with a raised
// code segment shares all inputs and is used for the resume-PC clamp.
module tb_trap_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inter_req = 1'b0;
   logic [31:0] inter_addr = '0;
   logic [2:0]  inter_sel = '0;
   logic        mret = 1'b0;
   logic        stall = 1'b0;
   logic [31:0] pc_cur = '0;
   logic [31:0] epc_rdata = '0;
   logic        epc_we, flush, pc_redirect, inter_ack, in_handler, busy;
   logic [31:0] epc_wdata, pc_target;
   logic [2:0]  cause;
   logic        c_epc_we, c_flush, c_pc_redirect, c_inter_ack, c_in_handler, c_busy;
   logic [31:0] c_epc_wdata, c_pc_target;
   logic [2:0]  c_cause;
   int          n_checks = 0;
   int          n_fail = 0;
   logic        ack_seen = 1'b0;

   trap_sequencer #(.XLEN(32), .CODE_SEGMENT(32'h0000_0000), .DRAIN_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .inter_req(inter_req), .inter_addr(inter_addr),
      .inter_sel(inter_sel), .mret(mret), .stall(stall), .pc_cur(pc_cur),
      .epc_rdata(epc_rdata), .epc_we(epc_we), .epc_wdata(epc_wdata), .flush(flush),
      .pc_redirect(pc_redirect), .pc_target(pc_target), .inter_ack(inter_ack),
      .in_handler(in_handler), .cause(cause), .busy(busy));

   trap_sequencer #(.XLEN(32), .CODE_SEGMENT(32'h0000_1000), .DRAIN_CYCLES(2)) dut_c (
      .clk(clk), .rst(rst), .inter_req(inter_req), .inter_addr(inter_addr),
      .inter_sel(inter_sel), .mret(mret), .stall(stall), .pc_cur(pc_cur),
      .epc_rdata(epc_rdata), .epc_we(c_epc_we), .epc_wdata(c_epc_wdata), .flush(c_flush),
      .pc_redirect(c_pc_redirect), .pc_target(c_pc_target), .inter_ack(c_inter_ack),
      .in_handler(c_in_handler), .cause(c_cause), .busy(c_busy));

   always #5 clk = ~clk;

   always @(posedge clk) if (inter_ack) ack_seen <= 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      #3;
      check("rst_busy", 32'(busy), 0);
      check("rst_flush", 32'(flush), 0);
      check("rst_redir", 32'(pc_redirect), 0);
      check("rst_target", pc_target, 0);
      check("rst_epc_we", 32'(epc_we), 0);
      check("rst_cause", 32'(cause), 0);
      tick;
      rst = 1'b1;
      tick;

      // basic entry
      inter_req = 1'b1; inter_addr = 32'h40; inter_sel = 3'b010; pc_cur = 32'h100;
      tick;
      inter_req = 1'b0;
      settle;
      check("b_epc_we", 32'(epc_we), 1);
      check("b_epc_wdata", epc_wdata, 32'h100);
      check("b_busy", 32'(busy), 1);
      check("b_c1_flush", 32'(flush), 0);
      tick;
      check("b_c2_flush", 32'(flush), 1);
      check("b_c2_epc_we", 32'(epc_we), 0);
      tick;
      check("b_c3_flush", 32'(flush), 1);
      check("b_c3_redir", 32'(pc_redirect), 0);
      tick;
      check("b_c4_redir", 32'(pc_redirect), 1);
      check("b_c4_target", pc_target, 32'h40);
      check("b_c4_ack", 32'(inter_ack), 1);
      check("b_c4_flush", 32'(flush), 0);
      tick;
      check("b_hnd", 32'(in_handler), 1);
      check("b_cause", 32'(cause), 2);
      check("b_hnd_ack", 32'(inter_ack), 0);
      check("b_hnd_redir", 32'(pc_redirect), 0);

      // return
      epc_rdata = 32'h104; mret = 1'b1;
      tick;
      mret = 1'b0;
      check("r_c1_flush", 32'(flush), 1);
      tick;
      check("r_c2_flush", 32'(flush), 1);
      tick;
      check("r_redir", 32'(pc_redirect), 1);
      check("r_target", pc_target, 32'h104);
      check("r_ack", 32'(inter_ack), 0);
      tick;
      check("r_busy", 32'(busy), 0);
      check("r_hnd", 32'(in_handler), 0);
      check("r_cause_hold", 32'(cause), 2);

      // stall at the boundary for three cycles
      inter_req = 1'b1; stall = 1'b1;
      tick;
      inter_req = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         settle;
         check("s_epc_we_stalled", 32'(epc_we), 0);
         check("s_busy", 32'(busy), 1);
         if (i < 3) tick;
      end
      tick;
      stall = 1'b0;
      settle;
      check("s_epc_we", 32'(epc_we), 1);
      tick;
      check("s_c5_flush", 32'(flush), 1);
      check("s_c5_epc_we", 32'(epc_we), 0);
      tick;
      check("s_c6_flush", 32'(flush), 1);
      check("s_c6_redir", 32'(pc_redirect), 0);
      tick;
      check("s_c7_redir", 32'(pc_redirect), 1);
      check("s_c7_ack", 32'(inter_ack), 1);
      tick;
      check("s_hnd", 32'(in_handler), 1);

      // mret and a held request together in the handler
      inter_req = 1'b1; inter_addr = 32'h80; inter_sel = 3'd5; pc_cur = 32'h200; mret = 1'b1;
      tick;
      mret = 1'b0;
      check("n_f1_ack", 32'(inter_ack), 0);
      check("n_f1_flush", 32'(flush), 1);
      tick;
      check("n_f2_ack", 32'(inter_ack), 0);
      tick;
      check("n_rr_redir", 32'(pc_redirect), 1);
      check("n_rr_target", pc_target, 32'h104);
      check("n_rr_ack", 32'(inter_ack), 0);
      tick;
      check("n_idle_busy", 32'(busy), 0);
      check("n_idle_epc_we", 32'(epc_we), 0);
      tick;
      inter_req = 1'b0;
      settle;
      check("n_re_epc_we", 32'(epc_we), 1);
      check("n_re_wdata", epc_wdata, 32'h200);
      check("n_re_cause", 32'(cause), 5);
      tick;
      tick;
      tick;
      check("n_re_target", pc_target, 32'h80);
      check("n_re_ack", 32'(inter_ack), 1);
      tick;
      mret = 1'b1;
      tick;
      mret = 1'b0;
      tick;
      tick;
      tick;
      check("n_end_busy", 32'(busy), 0);

      // clamp below the code segment, and the boundary value itself
      inter_req = 1'b1; inter_addr = 32'h2000; pc_cur = 32'h800; stall = 1'b1;
      tick;
      inter_req = 1'b0;
      check("c_we_stalled", 32'(c_epc_we), 0);
      check("c_clamp", c_epc_wdata, 32'h1000);
      check("c_unclamped", epc_wdata, 32'h800);
      pc_cur = 32'hFFF;
      settle;
      check("c_clamp_fff", c_epc_wdata, 32'h1000);
      pc_cur = 32'h1000;
      settle;
      check("c_edge", c_epc_wdata, 32'h1000);
      pc_cur = 32'h1004;
      settle;
      check("c_above", c_epc_wdata, 32'h1004);
      stall = 1'b0;
      settle;
      check("c_epc_we", 32'(c_epc_we), 1);

      // asynchronous reset in the middle of FLUSH
      tick;
      check("x_flush_before", 32'(flush), 1);
      ack_seen = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("x_flush", 32'(flush), 0);
      check("x_redir", 32'(pc_redirect), 0);
      check("x_busy", 32'(busy), 0);
      check("x_c_busy", 32'(c_busy), 0);
      tick;
      tick;
      tick;
      check("x_no_ack", 32'(ack_seen), 0);
      check("x_cause", 32'(cause), 0);
      rst = 1'b1;
      tick;
      inter_req = 1'b1; inter_addr = 32'h60; inter_sel = 3'd7; pc_cur = 32'h300;
      tick;
      inter_req = 1'b0;
      settle;
      check("x_re_epc_we", 32'(epc_we), 1);
      check("x_re_wdata", epc_wdata, 32'h300);
      tick;
      tick;
      tick;
      check("x_re_target", pc_target, 32'h60);
      check("x_re_ack", 32'(inter_ack), 1);
      tick;
      check("x_re_cause", 32'(cause), 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
